// File: rtl/scan_chain_driver.sv
// Tester-side scan chain controller: shifts a pattern into the chain MSB first
// on SE pulses, unloads the previous contents from SO, and compares them with an expected word.
module scan_chain_driver #(
    parameter int CHAIN_LEN = 4,
    parameter int CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] unload,
    output logic                 pass
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        CHECK
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_dec;
    logic [CHAIN_LEN-1:0] pattern_reg;
    logic [CHAIN_LEN-1:0] expected_reg;

    assign cnt_dec = cnt - 1'b1;

    // NOTE: SE comes straight from a flop (never from decoded state) so the
    // chain's shift clock cannot glitch; all state uses non-blocking updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            pattern_reg  <= '0;
            expected_reg <= '0;
            SE           <= 1'b0;
            SI           <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            unload       <= '0;
            pass         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    SE   <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        pattern_reg  <= pattern;
                        expected_reg <= expected;
                        cnt          <= CNT_W'(CHAIN_LEN - 1);
                        unload       <= '0;
                        pass         <= 1'b0;
                        busy         <= 1'b1;
                        SI           <= pattern[CHAIN_LEN-1];
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    // SO still shows the bit that the coming SE edge shifts out
                    unload <= {unload[CHAIN_LEN-2:0], SO};
                    SE     <= 1'b1;
                    state  <= PULSE;
                end
                PULSE: begin
                    SE <= 1'b0;
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (unload == expected_reg);
                        state <= CHECK;
                    end else begin
                        cnt   <= cnt_dec;
                        SI    <= pattern_reg[cnt_dec];
                        state <= SETUP;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_driver.sv
// Self-checking bench for scan_chain_driver: a behavioural scan chain answers
// SE/SI, and each run is compared with the chain's prior contents and the pattern.
module tb_scan_chain_driver;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] pattern = '0;
    logic [N-1:0] expected = '0;
    logic         SO;
    logic         SE, SI, busy, done, pass;
    logic [N-1:0] unload;

    int tests = 0;
    int fails = 0;

    scan_chain_driver #(.CHAIN_LEN(N), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
        .expected(expected), .SO(SO), .SE(SE), .SI(SI), .busy(busy),
        .done(done), .unload(unload), .pass(pass)
    );

    always #5 clk = ~clk;

    // Behavioural chain: shifts SI in on every SE rising edge, SO is its MSB
    logic [N-1:0] chain = '0;
    logic [N-1:0] si_word = '0;
    int           se_count = 0;
    int           done_count = 0;
    int           se_double = 0;
    logic         prev_se = 1'b0;

    assign SO = chain[N-1];

    always @(posedge SE) begin
        se_count++;
        si_word = {si_word[N-2:0], SI};
        chain   = {chain[N-2:0], SI};
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
        if (SE === 1'b1 && prev_se === 1'b1) se_double++;
        prev_se = SE;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete run; optionally pokes start at cycles 3 and 8 of the run
    task automatic run(input logic [N-1:0] p, input logic [N-1:0] e, input bit inject);
        logic [N-1:0] prior;
        int se0, done0, k;
        @(negedge clk);
        prior    = chain;
        se0      = se_count;
        done0    = done_count;
        start    = 1'b1;
        pattern  = p;
        expected = e;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        k = 1;
        while (done !== 1'b1 && k < 60) begin
            start   = inject && (k == 3 || k == 8);
            pattern = N'($urandom);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("done_latency", k, 2 * N + 1);
        check("busy_in_check", busy, 0);
        check("unload", unload, prior);
        check("pass", pass, prior == e);
        check("se_pulses", se_count - se0, N);
        check("si_sequence", si_word, p);
        check("chain_loaded", chain, p);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("unload_held", unload, prior);
        check("pass_held", pass, prior == e);
        check("done_count", done_count - done0, 1);
    endtask

    initial begin
        logic [N-1:0] p, e;
        #1;
        check("rst_se", SE, 0);
        check("rst_si", SI, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_unload", unload, 0);
        check("rst_pass", pass, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(4'b1011, 4'b0000, 0);
        run(4'b0110, 4'b1011, 0);
        run(4'b0000, 4'b1111, 0);
        check("fail_run_pass", pass, 0);
        run(4'b1001, 4'b0000, 1);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        start   = 1'b1;
        pattern = 4'b1110;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_se", SE, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_unload", unload, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(4'b0101, chain, 0);

        for (int i = 0; i < 20; i++) begin
            p = N'($urandom);
            e = ($urandom_range(0, 1) == 1) ? chain : N'($urandom);
            run(p, e, $urandom_range(0, 3) == 0);
        end

        check("se_never_double", se_double, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
